audio_sample_pacer: RTL and testbench
=====================================

Name: audio_sample_pacer

Overview:
- Sits between audio_generator and Audio_Controller, replacing the direct 50 MHz register path from generator output to codec channels.
- Samples the free-running generator output at a fixed sample rate derived from CLOCK_50 and gates it with Play, zero-filling when not playing.
- Buffers samples in a small FIFO and hands them to Audio_Controller one at a time using the write_audio_out / audio_out_allowed handshake.
- Primes the FIFO before draining and flushes it on every playback start, so each start is click-free.

Parameters:
- DATA_W, 32: sample width, matching left/right_channel_audio_out.
- DEPTH_LOG2, 4: log2 of FIFO depth (default depth 16).
- TICK_DIV, 1042: CLOCK_50 cycles per sample tick (50 MHz / 1042 ≈ 47.98 kHz); legal range >= 2.
- PRIME_LVL, 4: FIFO level that must be reached before draining starts; legal range 1..2^DEPTH_LOG2.

Ports:
- CLOCK_50  in  1  system clock, the only clock.
- reset  in  1  synchronous, active-high reset.
- sample_in  in  DATA_W  signed audio sample from audio_generator Out.
- play  in  1  playback enable from loop_counter Play.
- audio_out_allowed  in  1  Audio_Controller has space for a sample.
- write_audio_out  out  1  one-cycle strobe; channel data is valid in the same cycle.
- left_channel_audio_out  out  DATA_W  sample to the codec, left channel.
- right_channel_audio_out  out  DATA_W  same value as the left channel.
- fifo_level  out  DEPTH_LOG2+1  current FIFO occupancy, 0..2^DEPTH_LOG2.
- overflow  out  1  one-cycle pulse when a ticked sample is dropped.

Behaviour:
- Clocking and reset:
  - Single clock domain. All state changes on posedge CLOCK_50.
  - reset has priority over every other event.
  - Reset values: tick counter 0; FIFO empty; fifo_level 0; state FILL; write_audio_out 0; both channel outputs 0; overflow 0; play_d 0.
- Tick generation:
  - Counter runs 0..TICK_DIV-1 and wraps to 0.
  - tick is high in the cycle where the counter equals TICK_DIV-1.
  - The counter free-runs; play does not affect it.
- Capture:
  - On a tick cycle the push value is sample_in when play=1, otherwise 0.
  - The push is accepted if the FIFO is not full, or if it is full and a pop occurs in the same cycle.
  - Otherwise the sample is dropped, the FIFO is unchanged, and overflow pulses the next cycle.
- Play-edge flush:
  - play_d is a registered copy of play.
  - When play=1 and play_d=0, the FIFO is cleared and the state is forced to FILL.
  - A tick in that same cycle pushes into the freshly emptied FIFO, so level = 1 next cycle.
  - The flush overrides any pop in that cycle.
- State machine:
  - FILL: no pops. Go to RUN when fifo_level >= PRIME_LVL.
  - RUN: a pop occurs when audio_out_allowed=1, the FIFO is not empty, and write_audio_out=0 (at most one pop every 2 cycles). RUN stays in RUN when the FIFO empties; it returns to FILL only on reset or a play rising edge.
- Output:
  - A pop registers the head sample onto both channel outputs and sets write_audio_out=1 for exactly one cycle.
  - Channel outputs hold their value between pops.
- Level and latency:
  - Simultaneous push and pop leaves the level unchanged.
  - fifo_level is registered and always equals pushes minus pops since the last flush or reset.
  - Latency: a sample ticked at cycle T is stored at T+1; its earliest write_audio_out strobe is at T+2, given RUN, an empty FIFO before it, and audio_out_allowed=1.
- Wrap-around: read and write pointers wrap modulo 2^DEPTH_LOG2. Full and empty are distinguished by the extra level bit.
- Reset mid-operation discards all buffered samples. No write_audio_out is issued in the reset cycle.

Optional Feature:
- Macro: AUDIO_PACER_STATS_EN.
- When defined:
  - Adds outputs overflow_count[15:0] and pop_count[15:0].
  - overflow_count increments on each dropped sample and saturates at 16'hFFFF.
  - pop_count increments on each write_audio_out strobe and wraps.
  - Both counters clear on reset only; a flush does not clear them.
- When undefined, neither port nor counter exists, and the rest of the behaviour is identical.

Test Plan:
- Bench parameters: TICK_DIV=8, DEPTH_LOG2=2, PRIME_LVL=2.
- Reset: hold reset 3 cycles -> all outputs 0, fifo_level=0, no write_audio_out strobe for 20 cycles after release with play=0 and audio_out_allowed=0.
- Priming: play=1, sample_in=32'h0000_1234, audio_out_allowed=1 -> no strobe until 2 ticks are stored; first strobe carries 32'h0000_1234 on both channels, exactly 1 cycle wide.
- Zero-fill: play=0, sample_in=32'hFFFF_0001, state RUN -> each strobe carries 32'h0; one strobe per tick in steady state.
- Overflow: audio_out_allowed=0 for 6 ticks -> fifo_level saturates at 4; ticks 5 and 6 each pulse overflow once; with AUDIO_PACER_STATS_EN, overflow_count=2.
- Flush: FIFO at level 3 in RUN, play toggles 0->1 -> fifo_level=0 (or 1 if a tick coincides), state FILL, no strobe until level reaches 2 again.
- Reset mid-stream: assert reset while write_audio_out is pending -> next cycle write_audio_out=0, fifo_level=0, channel outputs 0.

Source files
------------

// File: rtl/audio_sample_pacer.sv
// -----------------------------------------------------------------------------
// audio_sample_pacer
//
// Purpose:
//   Sits between the free-running audio generator and the codec controller.
//   A tick divider samples the generator output at a fixed audio rate. The
//   sample is gated with play, so the captured value is zero when playback
//   is stopped. Samples are buffered in a small FIFO and handed to the
//   controller one at a time over the write_audio_out / audio_out_allowed
//   handshake.
//
//   On every rising edge of play the FIFO is flushed. Draining waits until
//   PRIME_LVL samples have been collected, so each playback start begins
//   from a clean, primed buffer and does not click.
//
// Ports:
//   CLOCK_50                 in   system clock, the only clock
//   reset                    in   synchronous, active-high reset
//   sample_in     [DATA_W]   in   signed sample from the generator
//   play                     in   playback enable
//   audio_out_allowed        in   controller can accept a sample
//   write_audio_out          out  one-cycle strobe, channel data valid with it
//   left_channel_audio_out   out  sample for the left channel
//   right_channel_audio_out  out  same value as the left channel
//   fifo_level [DEPTH_LOG2+1] out current FIFO occupancy, 0..2^DEPTH_LOG2
//   overflow                 out  one-cycle pulse after a ticked sample drops
//
// Optional build macro AUDIO_PACER_STATS_EN adds two outputs:
//   overflow_count [16]      out  dropped samples, saturates at 16'hFFFF
//   pop_count      [16]      out  strobes issued, wraps
//   Both counters are cleared by reset only. A flush does not clear them.
// -----------------------------------------------------------------------------
module audio_sample_pacer #(
  parameter int DATA_W     = 32,
  parameter int DEPTH_LOG2 = 4,
  parameter int TICK_DIV   = 1042,
  parameter int PRIME_LVL  = 4
) (
  input  logic                  CLOCK_50,
  input  logic                  reset,
  input  logic [DATA_W-1:0]     sample_in,
  input  logic                  play,
  input  logic                  audio_out_allowed,
  output logic                  write_audio_out,
  output logic [DATA_W-1:0]     left_channel_audio_out,
  output logic [DATA_W-1:0]     right_channel_audio_out,
  output logic [DEPTH_LOG2:0]   fifo_level,
  output logic                  overflow
`ifdef AUDIO_PACER_STATS_EN
  ,
  output logic [15:0]           overflow_count,
  output logic [15:0]           pop_count
`endif
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int LVL_W = DEPTH_LOG2 + 1;

  localparam logic [CNT_W-1:0] TICK_LAST = CNT_W'(TICK_DIV - 1);
  localparam logic [LVL_W-1:0] LVL_FULL  = LVL_W'(DEPTH);
  localparam logic [LVL_W-1:0] LVL_PRIME = LVL_W'(PRIME_LVL);

  typedef enum logic [0:0] {
    ST_FILL = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t                 state;
  state_t                 state_next;

  logic [CNT_W-1:0]       tick_cnt;
  logic                   tick;
  logic                   play_d;
  logic                   flush;

  logic [DATA_W-1:0]      mem [DEPTH];
  logic [DEPTH_LOG2-1:0]  wr_ptr;
  logic [DEPTH_LOG2-1:0]  rd_ptr;
  logic [DEPTH_LOG2-1:0]  wr_addr;
  logic                   fifo_empty;
  logic                   fifo_full;

  logic                   push;
  logic                   pop;
  logic                   drop;
  logic [DATA_W-1:0]      push_data;

  // ---------------------------------------------------------------------------
  // Sample-rate tick. Free-running and independent of play.
  // ---------------------------------------------------------------------------
  assign tick = (tick_cnt == TICK_LAST);

  // NOTE: clocked state is updated only with non-blocking assignments, so
  // every always_ff block reads pre-edge values regardless of block order.
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      tick_cnt <= '0;
    end else if (tick) begin
      tick_cnt <= '0;
    end else begin
      tick_cnt <= tick_cnt + CNT_W'(1);
    end
  end

  // ---------------------------------------------------------------------------
  // Handshake and FIFO control.
  // A flush cancels any pop in the same cycle. The FIFO is empty after a
  // flush, so a coinciding tick is always accepted. When the FIFO is full, a
  // same-cycle pop frees the slot the push needs.
  // ---------------------------------------------------------------------------
  assign flush      = play & ~play_d;
  assign fifo_empty = (fifo_level == '0);
  assign fifo_full  = (fifo_level == LVL_FULL);

  // The ~write_audio_out term limits the rate to one pop per two cycles.
  // The controller sees each strobe before the next sample is offered.
  assign pop  = (state == ST_RUN) & audio_out_allowed & ~fifo_empty &
                ~write_audio_out & ~flush;
  assign push = tick & (flush | ~fifo_full | pop);
  assign drop = tick & ~push;

  assign push_data = play ? sample_in : '0;
  assign wr_addr   = flush ? '0 : wr_ptr;

  // ---------------------------------------------------------------------------
  // FSM: FILL primes the buffer, RUN drains it. RUN is left only on a flush
  // or a reset. An empty FIFO in RUN simply waits for the next tick.
  // ---------------------------------------------------------------------------
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state <= ST_FILL;
    end else begin
      state <= state_next;
    end
  end

  // NOTE: state_next gets its default before any branch, so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    state_next = state;
    if (flush) begin
      state_next = ST_FILL;
    end else begin
      case (state)
        ST_FILL: if (fifo_level >= LVL_PRIME) state_next = ST_RUN;
        ST_RUN:  state_next = ST_RUN;
        default: state_next = ST_FILL;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // FIFO pointers and level. The pointers wrap modulo DEPTH. The extra level
  // bit tells a full FIFO apart from an empty one.
  // ---------------------------------------------------------------------------
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_level <= '0;
    end else if (flush) begin
      rd_ptr     <= '0;
      wr_ptr     <= push ? DEPTH_LOG2'(1) : '0;
      fifo_level <= push ? LVL_W'(1) : '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + DEPTH_LOG2'(1);
      if (pop)  rd_ptr <= rd_ptr + DEPTH_LOG2'(1);
      case ({push, pop})
        2'b10:   fifo_level <= fifo_level + LVL_W'(1);
        2'b01:   fifo_level <= fifo_level - LVL_W'(1);
        default: fifo_level <= fifo_level;
      endcase
    end
  end

  // NOTE: the sample storage has no reset. Validity is tracked entirely by
  // the pointers and the level, so the storage can map onto plain RAM.
  always_ff @(posedge CLOCK_50) begin
    if (push) begin
      mem[wr_addr] <= push_data;
    end
  end

  // ---------------------------------------------------------------------------
  // Output register. When the FIFO is full, a pop and a push can hit the
  // same slot in one cycle. The pop still reads the old head, because the
  // write lands at the clock edge.
  // ---------------------------------------------------------------------------
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      play_d                  <= 1'b0;
      overflow                <= 1'b0;
      write_audio_out         <= 1'b0;
      left_channel_audio_out  <= '0;
      right_channel_audio_out <= '0;
    end else begin
      play_d          <= play;
      overflow        <= drop;
      write_audio_out <= pop;
      if (pop) begin
        left_channel_audio_out  <= mem[rd_ptr];
        right_channel_audio_out <= mem[rd_ptr];
      end
    end
  end

`ifdef AUDIO_PACER_STATS_EN
  // ---------------------------------------------------------------------------
  // Statistics counters. Cleared by reset only.
  // ---------------------------------------------------------------------------
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      overflow_count <= '0;
      pop_count      <= '0;
    end else begin
      if (drop && (overflow_count != 16'hFFFF)) begin
        overflow_count <= overflow_count + 16'd1;
      end
      if (pop) begin
        pop_count <= pop_count + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_audio_sample_pacer.sv
// -----------------------------------------------------------------------------
// tb_audio_sample_pacer
//
// Self-checking bench for audio_sample_pacer, configured with TICK_DIV=8,
// DEPTH_LOG2=2 and PRIME_LVL=2.
//
// The reference model treats the buffer as a queue of samples. It keeps a
// primed/running flag and counts elapsed cycles to locate the sample ticks.
// Directed phases cover reset, priming, zero-fill, overflow, flush and a
// reset mid-stream. A randomized phase follows them.
// -----------------------------------------------------------------------------
module tb_audio_sample_pacer;

  localparam int DATA_W     = 32;
  localparam int DEPTH_LOG2 = 2;
  localparam int TICK_DIV   = 8;
  localparam int PRIME_LVL  = 2;
  localparam int DEPTH      = 1 << DEPTH_LOG2;

  logic                CLOCK_50;
  logic                reset;
  logic [DATA_W-1:0]   sample_in;
  logic                play;
  logic                audio_out_allowed;
  logic                write_audio_out;
  logic [DATA_W-1:0]   left_channel_audio_out;
  logic [DATA_W-1:0]   right_channel_audio_out;
  logic [DEPTH_LOG2:0] fifo_level;
  logic                overflow;
`ifdef AUDIO_PACER_STATS_EN
  logic [15:0]         overflow_count;
  logic [15:0]         pop_count;
`endif

  audio_sample_pacer #(
    .DATA_W    (DATA_W),
    .DEPTH_LOG2(DEPTH_LOG2),
    .TICK_DIV  (TICK_DIV),
    .PRIME_LVL (PRIME_LVL)
  ) dut (
    .CLOCK_50               (CLOCK_50),
    .reset                  (reset),
    .sample_in              (sample_in),
    .play                   (play),
    .audio_out_allowed      (audio_out_allowed),
    .write_audio_out        (write_audio_out),
    .left_channel_audio_out (left_channel_audio_out),
    .right_channel_audio_out(right_channel_audio_out),
    .fifo_level             (fifo_level),
    .overflow               (overflow)
`ifdef AUDIO_PACER_STATS_EN
    ,
    .overflow_count         (overflow_count),
    .pop_count              (pop_count)
`endif
  );

  initial CLOCK_50 = 1'b0;
  always #5 CLOCK_50 = ~CLOCK_50;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model, one call per clock cycle.
  // ---------------------------------------------------------------------------
  int          m_cyc;
  logic [31:0] m_q[$];
  bit          m_run;
  bit          m_play_d;
  bit          m_wr;
  bit          m_ovf;
  bit          m_tick;
  logic [31:0] m_chan;
  int          m_ovf_cnt;
  int          m_pop_cnt;

  task automatic model_step(input bit r, input bit p, input logic [31:0] s, input bit a);
    bit rise;
    bit pop_now;
    bit new_run;
    if (r) begin
      m_cyc = 0; m_q.delete(); m_run = 0; m_play_d = 0; m_wr = 0; m_ovf = 0;
      m_tick = 0; m_chan = '0; m_ovf_cnt = 0; m_pop_cnt = 0;
      return;
    end
    m_tick  = ((m_cyc % TICK_DIV) == TICK_DIV - 1);
    m_cyc++;
    rise    = p && !m_play_d;
    pop_now = m_run && a && (m_q.size() != 0) && !m_wr && !rise;
    new_run = rise ? 1'b0 : (m_run || (m_q.size() >= PRIME_LVL));
    if (rise) m_q.delete();
    if (pop_now) begin
      m_chan    = m_q.pop_front();
      m_pop_cnt = (m_pop_cnt + 1) % 65536;
    end
    m_wr  = pop_now;
    m_ovf = 0;
    if (m_tick) begin
      if (m_q.size() < DEPTH) m_q.push_back(p ? s : 32'h0);
      else begin
        m_ovf = 1;
        if (m_ovf_cnt < 65535) m_ovf_cnt++;
      end
    end
    m_run    = new_run;
    m_play_d = p;
  endtask

  // Drives one cycle from a falling edge, advances the model, then compares
  // every output at the next falling edge.
  task automatic step(input bit r, input bit p, input logic [31:0] s, input bit a);
    reset = r; play = p; sample_in = s; audio_out_allowed = a;
    model_step(r, p, s, a);
    @(posedge CLOCK_50);
    @(negedge CLOCK_50);
    check("write_audio_out", write_audio_out, m_wr);
    check("fifo_level", fifo_level, m_q.size());
    check("overflow", overflow, m_ovf);
    check("left_channel", left_channel_audio_out, m_chan);
    check("right_channel", right_channel_audio_out, m_chan);
`ifdef AUDIO_PACER_STATS_EN
    check("overflow_count", overflow_count, m_ovf_cnt);
    check("pop_count", pop_count, m_pop_cnt);
`endif
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int  n;
    int  ticks;
    int  dut_idx;
    int  mdl_idx;
    bit  found;
    bit  p;
    bit  a;

    reset = 1'b1; play = 1'b0; sample_in = '0; audio_out_allowed = 1'b0;
    @(negedge CLOCK_50);

    // Reset, then idle with no handshake.
    repeat (3) step(1, 0, 32'h0, 0);
    check("reset_level", fifo_level, 0);
    check("reset_write", write_audio_out, 0);
    check("reset_left", left_channel_audio_out, 0);
    n = 0;
    for (int i = 0; i < 20; i++) begin
      step(0, 0, 32'h0, 0);
      if (write_audio_out) n++;
    end
    check("idle_strobes", n, 0);

    // Priming: no strobe until PRIME_LVL ticks are stored.
    found = 0; dut_idx = -1; mdl_idx = -1;
    for (int i = 0; i < 60 && !found; i++) begin
      step(0, 1, 32'h0000_1234, 1);
      if (m_wr && mdl_idx < 0) mdl_idx = i;
      if (write_audio_out) begin
        found   = 1;
        dut_idx = i;
      end
    end
    check("prime_found", found, 1);
    check("prime_first_step", dut_idx, mdl_idx);
    check("prime_first_left", left_channel_audio_out, 32'h0000_1234);
    check("prime_first_right", right_channel_audio_out, 32'h0000_1234);
    step(0, 1, 32'h0000_1234, 1);
    check("prime_strobe_width", write_audio_out, 0);
    repeat (24) step(0, 1, 32'h0000_1234, 1);

    // Zero-fill while stopped and running.
    n = 0;
    for (int i = 0; i < 48; i++) begin
      step(0, 0, 32'hFFFF_0001, 1);
      if (write_audio_out) begin
        n++;
        if (i >= 4) check("zero_fill_data", left_channel_audio_out, 0);
      end
    end
    check("zero_fill_rate", (n >= 5), 1);

    // Overflow: drain first, then block the controller for six ticks.
    found = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      step(0, 0, 32'h0, 1);
      if (fifo_level == 0 && !write_audio_out) found = 1;
    end
    check("ovf_drained", found, 1);
    ticks = 0; n = 0;
    for (int i = 0; i < 60 && ticks < 6; i++) begin
      step(0, 0, 32'h0, 0);
      if (m_tick) ticks++;
      if (overflow) n++;
    end
    check("ovf_pulses", n, 2);
    check("ovf_level", fifo_level, 4);
`ifdef AUDIO_PACER_STATS_EN
    check("ovf_count_total", overflow_count, 2);
`endif

    // Flush: bring the level to 3, then raise play.
    for (int i = 0; i < 16 && fifo_level != 3; i++) step(0, 0, 32'h0, (fifo_level == 4));
    check("flush_pre_level", fifo_level, 3);
    step(0, 1, 32'h0000_ABCD, 1);
    check("flush_level", fifo_level, m_tick ? 1 : 0);
    check("flush_no_strobe", write_audio_out, 0);
    found = 0; ticks = m_tick ? 1 : 0;
    for (int i = 0; i < 40 && !found; i++) begin
      step(0, 1, 32'h0000_ABCD, 1);
      if (m_tick) ticks++;
      if (write_audio_out) found = 1;
    end
    check("flush_refill_found", found, 1);
    check("flush_ticks_before_strobe", (ticks >= PRIME_LVL), 1);
    check("flush_data", left_channel_audio_out, 32'h0000_ABCD);

    // Reset while a pop is pending.
    found = 0;
    for (int i = 0; i < 40 && !found; i++) begin
      step(0, 1, 32'h0000_5555, 1);
      if (fifo_level != 0 && !write_audio_out) found = 1;
    end
    check("midreset_pending", found, 1);
    step(1, 1, 32'h0000_5555, 1);
    check("midreset_write", write_audio_out, 0);
    check("midreset_level", fifo_level, 0);
    check("midreset_left", left_channel_audio_out, 0);
    check("midreset_right", right_channel_audio_out, 0);
    repeat (2) step(0, 0, 32'h0, 0);

    // Randomized traffic.
    p = 0;
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 39) == 0) p = ~p;
      a = ($urandom_range(0, 3) != 0);
      step(($urandom_range(0, 399) == 0), p, $urandom, a);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
